// File: rtl/mips_data_mem.sv
// mips_data_mem: data-memory bus target for the MIPS core.
// Word-addressed RAM behind an IDLE -> WAIT -> DONE handshake with
// WAIT_CYCLES programmable wait states and a one-cycle mips_Ready pulse.
// Optional feature macro: MIPS_DATA_MEM_ALIGN_CHECK_EN (misaligned
// accesses are flagged on mips_AddrErr and have no effect on RAM/read data).
module mips_data_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mips_Address,
  input  logic        mips_MemRead,
  input  logic        mips_MemWrite,
  input  logic [31:0] mips_Write_data,
  output logic [31:0] mips_Read_data,
  output logic        mips_Ready,
  output logic        mips_AddrErr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_q, state_n;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             data_q;
  logic                    we_q;
  logic                    err_q;

  logic [31:0]             mem [2**ADDR_WIDTH];

  logic                    req;
  logic                    in_err;
  logic                    go_done;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_data;
  logic                    acc_we;
  logic                    acc_err;

  assign req = mips_MemRead | mips_MemWrite;

`ifdef MIPS_DATA_MEM_ALIGN_CHECK_EN
  assign in_err = |mips_Address[1:0];
`else
  assign in_err = 1'b0;
`endif

  // Upper address bits alias; low bits are only used by the alignment check.
  logic unused_addr;
  assign unused_addr = ^{mips_Address[31:ADDR_WIDTH+2], mips_Address[1:0]};

  // With zero wait states DONE is entered on the latch edge itself, so the
  // access uses the live bus values in IDLE and the latched copies otherwise.
  always_comb begin
    acc_idx  = idx_q;
    acc_data = data_q;
    acc_we   = we_q;
    acc_err  = err_q;
    if (state_q == IDLE) begin
      acc_idx  = mips_Address[ADDR_WIDTH+1:2];
      acc_data = mips_Write_data;
      acc_we   = mips_MemWrite;
      acc_err  = in_err;
    end
  end

  // Next-state logic; go_done marks the edge that enters DONE.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (req) state_n = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    go_done = (state_n == DONE) && (state_q != DONE);
  end

  // State, wait counter, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      idx_q          <= '0;
      data_q         <= 32'd0;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      mips_Ready     <= 1'b0;
      mips_Read_data <= 32'd0;
    end else begin
      state_q    <= state_n;
      mips_Ready <= go_done;
      if (state_q == IDLE && req) begin
        idx_q  <= mips_Address[ADDR_WIDTH+1:2];
        data_q <= mips_Write_data;
        we_q   <= mips_MemWrite;
        err_q  <= in_err;
        cnt_q  <= 4'(WAIT_CYCLES);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (go_done && !acc_we && !acc_err)
        mips_Read_data <= mem[acc_idx];
    end
  end

  // RAM write on DONE entry; gated by reset so an aborted write is dropped.
  always_ff @(posedge clk) begin
    if (rst && go_done && acc_we && !acc_err)
      mem[acc_idx] <= acc_data;
  end

`ifdef MIPS_DATA_MEM_ALIGN_CHECK_EN
  logic addr_err_q;
  // Error flag pulses together with mips_Ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err_q <= 1'b0;
    else      addr_err_q <= go_done && acc_err;
  end
  assign mips_AddrErr = addr_err_q;
`else
  assign mips_AddrErr = 1'b0;
`endif

endmodule

// File: tb/tb_mips_data_mem.sv
// Scoreboard bench for mips_data_mem: two instances (2 and 0 wait states)
// run the same transaction stream against an associative-array memory model.
module tb_mips_data_mem;
  localparam int AW = 10;
  localparam int W0 = 2;
  localparam int W1 = 0;
`ifdef MIPS_DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        mrd [2];
  logic        mwr [2];
  logic        rdy [2];
  logic        aerr [2];

  mips_data_mem #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) u0 (
    .clk(clk), .rst(rst), .mips_Address(addr[0]), .mips_MemRead(mrd[0]),
    .mips_MemWrite(mwr[0]), .mips_Write_data(wdata[0]),
    .mips_Read_data(rdata[0]), .mips_Ready(rdy[0]), .mips_AddrErr(aerr[0]));

  mips_data_mem #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W1)) u1 (
    .clk(clk), .rst(rst), .mips_Address(addr[1]), .mips_MemRead(mrd[1]),
    .mips_MemWrite(mwr[1]), .mips_Write_data(wdata[1]),
    .mips_Read_data(rdata[1]), .mips_Ready(rdy[1]), .mips_AddrErr(aerr[1]));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          k;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] mem_m [int];
  logic [31:0] last_rd = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int lane, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s lane%0d: got %h want %h", name, lane, got, want);
    end
  endtask

  // Monitor: pop an expectation whenever a lane presents mips_Ready.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (rst && rdy[g] === 1'b1) begin
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ready lane%0d: got ready=1 want no pending txn", g);
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("read_data", g, rdata[g], e.rdata);
          chk("addr_err", g, {31'd0, aerr[g]}, {31'd0, e.err});
          // Ready sampled at edge k+W+1 means it is visible right after edge k+W.
          chk("latency", g, cyc - e.k, (g == 0) ? W0 : W1);
        end
      end else if (rst) begin
        chk("addr_err_idle", g, {31'd0, aerr[g]}, 32'd0);
      end
    end
  end

  task automatic run_lane(input int g);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rdy[g] !== 1'b1 && t < 40);
    if (rdy[g] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout lane%0d: got no ready want ready within 40 cycles", g);
    end
    mrd[g] = 1'b0;
    mwr[g] = 1'b0;
  endtask

  // Issue one transaction to both lanes; must be called just after a negedge
  // with both instances idle.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int i;
    bit err;
    i   = int'(a[AW+1:2]);
    err = ALIGN && (a[1:0] != 2'b00);
    e.k = cyc + 1;
    e.err = err;
    if (wr) begin
      if (!err) mem_m[i] = d;
    end else if (!err) begin
      last_rd = mem_m[i];
    end
    e.rdata = last_rd;
    q0.push_back(e);
    q1.push_back(e);
    for (int g = 0; g < 2; g++) begin
      addr[g] = a; wdata[g] = d; mrd[g] = rd; mwr[g] = wr;
    end
    fork
      run_lane(0);
      run_lane(1);
    join
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int op;
    int idx;
    for (int g = 0; g < 2; g++) begin
      addr[g] = 32'd0; wdata[g] = 32'd0; mrd[g] = 1'b0; mwr[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_ready", g, {31'd0, rdy[g]}, 32'd0);
      chk("reset_rdata", g, rdata[g], 32'd0);
      chk("reset_aerr", g, {31'd0, aerr[g]}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 1'b1, 32'h1004, 32'h12345678);
    issue(1'b1, 1'b0, 32'h0004, 32'h0);
    issue(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    issue(1'b1, 1'b0, 32'h20, 32'h0);

    // Reset during WAIT on the 2-wait-state lane discards the write.
    issue(1'b0, 1'b1, 32'h30, 32'h11);
    addr[0] = 32'h30; wdata[0] = 32'hFFFFFFFF; mwr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 0, {31'd0, rdy[0]}, 32'd0);
    chk("rst_mid_rdata", 0, rdata[0], 32'd0);
    chk("rst_mid_rdata", 1, rdata[1], 32'd0);
    mwr[0] = 1'b0;
    last_rd = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b0, 32'h30, 32'h0);

    issue(1'b0, 1'b1, 32'h10, 32'h44);
    issue(1'b0, 1'b1, 32'h13, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 32'h10, 32'h0);

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      a[AW+1:2] = AW'($urandom_range(0, 15));
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      idx = int'(a[AW+1:2]);
      op = $urandom_range(0, 2);
      if (op == 0 && !mem_m.exists(idx)) op = 1;
      case (op)
        0:       issue(1'b1, 1'b0, a, 32'h0);
        1:       issue(1'b0, 1'b1, a, $urandom);
        default: issue(1'b1, 1'b1, a, $urandom);
      endcase
    end

    repeat (5) @(negedge clk);
    chk("pending_left", 0, q0.size(), 32'd0);
    chk("pending_left", 1, q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
